eth_type_filter: RTL

- Parametrised AXI-Stream EtherType filter for one port; per-port instances sit in the app block between the MAC-side RX stream and the host-side stream.
- Matches the frame EtherType (bytes 12-13) against a programmable table of RULE_COUNT entries.
- Passes or drops whole frames per a polarity mode, with fully handshaked output buffering, multi-beat header handling and per-frame statistics.

---
 rtl/eth_type_filter.sv | 224 ++++++++++++++++++++++
 1 files changed

// File: rtl/eth_type_filter.sv
// EtherType frame filter for one AXI-Stream port.
// The EtherType (bytes 12-13) of each frame is matched against RULE_COUNT
// programmable entries. Whole frames are then passed or dropped according
// to cfg_match_pass. Output goes through a 2-entry skid buffer whose head
// drives m_axis_* directly from registers.
module eth_type_filter #(
  parameter int DATA_WIDTH = 64,
  parameter int KEEP_WIDTH = DATA_WIDTH/8,
  parameter int USER_WIDTH = 1,
  parameter int RULE_COUNT = 4,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [DATA_WIDTH-1:0]  s_axis_tdata,
  input  logic [KEEP_WIDTH-1:0]  s_axis_tkeep,
  input  logic                   s_axis_tvalid,
  output logic                   s_axis_tready,
  input  logic                   s_axis_tlast,
  input  logic [USER_WIDTH-1:0]  s_axis_tuser,
  output logic [DATA_WIDTH-1:0]  m_axis_tdata,
  output logic [KEEP_WIDTH-1:0]  m_axis_tkeep,
  output logic                   m_axis_tvalid,
  input  logic                   m_axis_tready,
  output logic                   m_axis_tlast,
  output logic [USER_WIDTH-1:0]  m_axis_tuser,
  input  logic [RULE_COUNT*16-1:0] cfg_ethtype,
  input  logic [RULE_COUNT-1:0]  cfg_enable,
  input  logic                   cfg_match_pass,
  output logic [CNT_WIDTH-1:0]   stat_pass_count,
  output logic [CNT_WIDTH-1:0]   stat_drop_count,
  output logic                   stat_drop_pulse
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_HDR  = 2'd1;
  localparam logic [1:0] S_PASS = 2'd2;
  localparam logic [1:0] S_DROP = 2'd3;

  // With a 64-bit bus bytes 12-13 land in beat 1 at byte lanes 4-5.
  localparam bit IS64 = (DATA_WIDTH == 64);
  localparam int HB   = IS64 ? 4 : 12;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic [KEEP_WIDTH-1:0] keep;
    logic                  last;
    logic [USER_WIDTH-1:0] user;
  } beat_t;

  logic [1:0] r_state, w_state_n;
  beat_t      r_e0, r_e1, r_hold;
  beat_t      w_in, w_e0_n, w_e1_n, w_push_a_d;
  logic       r_v0, r_v1, w_v0_n, w_v1_n;

  logic [RULE_COUNT*16-1:0] r_cfg_type, w_cfg_type;
  logic [RULE_COUNT-1:0]    r_cfg_en, w_cfg_en;
  logic                     r_cfg_pass, w_cfg_pass;

  logic [15:0] w_etype;
  logic        w_match, w_runt, w_fwd, w_rdy, w_acc, w_pop;
  logic        w_push_a, w_push_b, w_hold_ld, w_fr_pass, w_fr_drop;

  logic [CNT_WIDTH-1:0] r_pass_cnt, r_drop_cnt;
  logic                 r_drop_pulse;

  assign w_in = {s_axis_tdata, s_axis_tkeep, s_axis_tlast, s_axis_tuser};

  // Config is live on the first beat, then the sampled copy holds for the frame.
  assign w_cfg_type = (r_state == S_IDLE) ? cfg_ethtype    : r_cfg_type;
  assign w_cfg_en   = (r_state == S_IDLE) ? cfg_enable     : r_cfg_en;
  assign w_cfg_pass = (r_state == S_IDLE) ? cfg_match_pass : r_cfg_pass;

  assign w_etype = {s_axis_tdata[HB*8 +: 8], s_axis_tdata[(HB+1)*8 +: 8]};
  assign w_runt  = s_axis_tlast & ~s_axis_tkeep[HB+1];
  assign w_fwd   = (w_match == w_cfg_pass) & ~w_runt;

  // Rule table match against the beat carrying bytes 12-13.
  always_comb begin
    w_match = 1'b0;
    for (int i = 0; i < RULE_COUNT; i++)
      if (w_cfg_en[i] && (w_cfg_type[16*i +: 16] == w_etype)) w_match = 1'b1;
  end

  // Input ready: a free buffer entry (HDR needs both), or always while dropping.
  always_comb begin
    w_rdy = 1'b0;
    case (r_state)
      S_IDLE, S_PASS: w_rdy = ~r_v1;
      S_HDR:          w_rdy = ~r_v0;
      S_DROP:         w_rdy = 1'b1;
      default:        w_rdy = 1'b0;
    endcase
    if (rst) w_rdy = 1'b0;
  end

  assign s_axis_tready = w_rdy;
  assign w_acc         = s_axis_tvalid & w_rdy;
  assign w_pop         = r_v0 & m_axis_tready;

  // Frame state machine: decides pass/drop and what to push into the buffer.
  always_comb begin
    w_state_n  = r_state;
    w_push_a   = 1'b0;
    w_push_b   = 1'b0;
    w_push_a_d = w_in;
    w_hold_ld  = 1'b0;
    w_fr_pass  = 1'b0;
    w_fr_drop  = 1'b0;
    if (w_acc) begin
      case (r_state)
        S_IDLE, S_HDR: begin
          if (IS64 && (r_state == S_IDLE)) begin
            // A single-beat frame cannot reach byte 13: runt.
            if (s_axis_tlast) w_fr_drop = 1'b1;
            else begin
              w_hold_ld = 1'b1;
              w_state_n = S_HDR;
            end
          end else if (w_fwd) begin
            w_push_a = 1'b1;
            if (r_state == S_HDR) begin
              w_push_a_d = r_hold;
              w_push_b   = 1'b1;
            end
            if (s_axis_tlast) begin
              w_fr_pass = 1'b1;
              w_state_n = S_IDLE;
            end else w_state_n = S_PASS;
          end else begin
            if (s_axis_tlast) begin
              w_fr_drop = 1'b1;
              w_state_n = S_IDLE;
            end else w_state_n = S_DROP;
          end
        end
        S_PASS: begin
          w_push_a = 1'b1;
          if (s_axis_tlast) begin
            w_fr_pass = 1'b1;
            w_state_n = S_IDLE;
          end
        end
        S_DROP: begin
          if (s_axis_tlast) begin
            w_fr_drop = 1'b1;
            w_state_n = S_IDLE;
          end
        end
        default: w_state_n = S_IDLE;
      endcase
    end
  end

  // Skid buffer next state: pop shifts e1 into e0, pushes fill the lowest free slot.
  always_comb begin
    w_e0_n = r_e0;
    w_e1_n = r_e1;
    w_v0_n = r_v0;
    w_v1_n = r_v1;
    if (w_pop) begin
      w_e0_n = r_e1;
      w_v0_n = r_v1;
      w_v1_n = 1'b0;
    end
    if (w_push_a) begin
      if (!w_v0_n) begin
        w_e0_n = w_push_a_d;
        w_v0_n = 1'b1;
      end else begin
        w_e1_n = w_push_a_d;
        w_v1_n = 1'b1;
      end
    end
    // Only from HDR, where both entries were free, so e0 took the held beat.
    if (w_push_b) begin
      w_e1_n = w_in;
      w_v1_n = 1'b1;
    end
  end

  // State, buffer, config snapshot and statistics registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_e0         <= '0;
      r_e1         <= '0;
      r_hold       <= '0;
      r_v0         <= 1'b0;
      r_v1         <= 1'b0;
      r_cfg_type   <= '0;
      r_cfg_en     <= '0;
      r_cfg_pass   <= 1'b0;
      r_pass_cnt   <= '0;
      r_drop_cnt   <= '0;
      r_drop_pulse <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_e0    <= w_e0_n;
      r_e1    <= w_e1_n;
      r_v0    <= w_v0_n;
      r_v1    <= w_v1_n;
      if (w_hold_ld) r_hold <= w_in;
      if (w_acc && (r_state == S_IDLE)) begin
        r_cfg_type <= cfg_ethtype;
        r_cfg_en   <= cfg_enable;
        r_cfg_pass <= cfg_match_pass;
      end
      if (w_fr_pass) r_pass_cnt <= r_pass_cnt + 1'b1;
      if (w_fr_drop) r_drop_cnt <= r_drop_cnt + 1'b1;
      r_drop_pulse <= w_fr_drop;
    end
  end

  assign m_axis_tdata    = r_e0.data;
  assign m_axis_tkeep    = r_e0.keep;
  assign m_axis_tlast    = r_e0.last;
  assign m_axis_tuser    = r_e0.user;
  assign m_axis_tvalid   = r_v0;
  assign stat_pass_count = r_pass_cnt;
  assign stat_drop_count = r_drop_cnt;
  assign stat_drop_pulse = r_drop_pulse;

endmodule
